seg7_scan_ctrl: RTL

- Time-multiplexed scan controller that shares one binary-to-7-segment decoder across DIGITS common-anode digits.
- Each cycle it presents one 4-bit nibble to the external decoder and drives the active-low anode enables.
- It runs a refresh prescaler and inserts a blanking gap between digits to suppress ghosting.
- Display data is double-buffered: new data takes effect only at frame boundaries.
- It sits between the datapath that produces display values and the shared decoder/segment pins.

---
 rtl/seg7_scan_ctrl.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment scan controller: one shared decoder, active-low anodes,
// blanking gap per digit slot, and double-buffered display data swapped at frame boundaries.
module seg7_scan_ctrl #(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned DIV    = 1000,
  parameter int unsigned BLANK  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   data,
  input  logic                  lzb,
  output logic                  load_ack,
  output logic [3:0]            nibble_out,
  output logic [DIGITS-1:0]     an_n,
  output logic                  frame_done
);

  localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CntW-1:0] CntBlankLast = CntW'(BLANK - 1);
  localparam logic [CntW-1:0] CntSlotLast  = CntW'(DIV - 1);
  localparam logic [IdxW-1:0] IdxLast      = IdxW'(DIGITS - 1);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StBlank = 2'd1;
  localparam logic [1:0] StShow  = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [4*DIGITS-1:0]   shadow_q, shadow_d;
  logic [4*DIGITS-1:0]   active_q, active_d;
  logic                  pending_q, pending_d;
  logic                  frame_start;
  logic                  xfer;

  logic [DIGITS-1:0]     blank_mask;
  logic                  zeros_above;

  logic [3:0]            nibble_d;
  logic [DIGITS-1:0]     an_n_d;
  logic                  load_ack_d;
  logic                  frame_done_d;

  // Scan sequencing: the prescaler runs 0..DIV-1 across the whole slot,
  // with BLANK occupying the first BLANK counts and SHOW the remainder.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    frame_start = 1'b0;
    if (!en) begin
      state_d = StIdle;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      case (state_q)
        StIdle: begin
          state_d     = StBlank;
          cnt_d       = '0;
          idx_d       = '0;
          frame_start = 1'b1;
        end
        StBlank: begin
          cnt_d = cnt_q + CntW'(1);
          if (cnt_q == CntBlankLast) begin
            state_d = StShow;
          end
        end
        StShow: begin
          if (cnt_q == CntSlotLast) begin
            cnt_d   = '0;
            state_d = StBlank;
            if (idx_q == IdxLast) begin
              idx_d       = '0;
              frame_start = 1'b1;
            end else begin
              idx_d = idx_q + IdxW'(1);
            end
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        default: begin
          state_d = StIdle;
          cnt_d   = '0;
          idx_d   = '0;
        end
      endcase
    end
  end

  // A load coinciding with a transfer is captured and keeps pending set.
  always_comb begin
    xfer      = frame_start & pending_q;
    active_d  = xfer ? shadow_q : active_q;
    shadow_d  = load ? data : shadow_q;
    pending_d = load | (pending_q & ~xfer);
  end

  // Digit i>=1 is blanked when it and every digit above it are zero.
  always_comb begin
    zeros_above = 1'b1;
    blank_mask  = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zeros_above   = zeros_above & (active_d[4*i +: 4] == 4'h0);
      blank_mask[i] = lzb & zeros_above;
    end
  end

  // Outputs are registered from next-state values so they line up with the state.
  always_comb begin
    nibble_d     = 4'h0;
    an_n_d       = '1;
    if (state_d != StIdle) begin
      nibble_d = active_d[4*int'(idx_d) +: 4];
    end
    if (state_d == StShow && !blank_mask[idx_d]) begin
      an_n_d[idx_d] = 1'b0;
    end
    frame_done_d = (state_d == StShow) && (idx_d == IdxLast) && (cnt_d == CntSlotLast);
    load_ack_d   = xfer;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      idx_q      <= '0;
      shadow_q   <= '0;
      active_q   <= '0;
      pending_q  <= 1'b0;
      nibble_out <= 4'h0;
      an_n       <= '1;
      load_ack   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shadow_q   <= shadow_d;
      active_q   <= active_d;
      pending_q  <= pending_d;
      nibble_out <= nibble_d;
      an_n       <= an_n_d;
      load_ack   <= load_ack_d;
      frame_done <= frame_done_d;
    end
  end

  an_n_at_most_one_low: assert property (@(posedge clk) disable iff (!rst_n)
    $countones(~an_n) <= 1);

endmodule
